// File: rtl/lz77_frame_ctrl.sv
// Frame sequencer for one LZ77 encoder core: per-frame core reset, fixed-length
// byte load, token collection into a small FIFO, and sticky coverage/overflow/underrun flags.
module lz77_frame_ctrl #(
   parameter int unsigned FRAME_LEN = 2049,
   parameter int unsigned TOK_DEPTH = 4,
   parameter logic [7:0]  TERM      = 8'h24
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        core_rst,
   output logic [7:0]  core_char,
   input  logic        core_valid,
   input  logic [3:0]  core_offset,
   input  logic [2:0]  core_len,
   input  logic [7:0]  core_nxt,
   input  logic        core_finish,
   output logic        tok_valid,
   input  logic        tok_ready,
   output logic [14:0] tok_data,
   output logic        busy,
   output logic        frame_done,
   output logic [2:0]  err
);

   localparam int unsigned BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
   localparam int unsigned PW = $clog2(TOK_DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [2:0] {IDLE, CRST, LOAD, ENC, DRAIN, DONE} state_t;

   state_t         state, state_nxt;
   logic [BW-1:0]  byte_cnt;
   logic [11:0]    cov_cnt;
   logic [7:0]     last_char;
   logic [14:0]    mem [TOK_DEPTH];
   logic [PW-1:0]  wr_ptr, rd_ptr;
   logic [CW-1:0]  count;
   logic           full, push_req, push, pop, cov_bad;
   logic [12:0]    cov_sum;

   assign full     = (count == CW'(TOK_DEPTH));
   assign tok_valid = (count != '0);
   assign tok_data = mem[rd_ptr];
   assign pop      = tok_valid & tok_ready;
   assign push_req = (state == ENC) & core_valid;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
   assign push     = push_req & (~full | pop);
   assign cov_sum  = {1'b0, cov_cnt} + 13'(core_len) + 13'd1;
   assign cov_bad  = (cov_cnt != 12'(FRAME_LEN)) || (last_char != TERM);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (in_valid) state_nxt = CRST;
         CRST:    state_nxt = LOAD;
         LOAD:    if (byte_cnt == BW'(FRAME_LEN - 1)) state_nxt = ENC;
         ENC:     if (core_finish) state_nxt = DRAIN;
         DRAIN:   if (!tok_valid) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      core_rst   = (state == IDLE) || (state == CRST);
      in_ready   = (state == LOAD);
      core_char  = ((state == LOAD) && in_valid) ? in_data : '0;
      busy       = (state != IDLE);
      frame_done = (state == DONE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         byte_cnt  <= '0;
         cov_cnt   <= '0;
         last_char <= '0;
         err       <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
      end else begin
         if (state == CRST)      byte_cnt <= '0;
         else if (state == LOAD) byte_cnt <= byte_cnt + 1'b1;

         if (state == DONE)  cov_cnt <= '0;
         else if (push_req)  cov_cnt <= cov_sum[12] ? '1 : cov_sum[11:0];
         if (push_req) last_char <= core_nxt;

         if ((state == LOAD) && !in_valid) err[0] <= 1'b1;
         if (push_req && !push)            err[1] <= 1'b1;
         // Coverage is judged on the DRAIN->DONE edge so err[2] is visible alongside frame_done.
         if ((state == DRAIN) && !tok_valid && cov_bad) err[2] <= 1'b1;

         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {core_offset, core_len, core_nxt};
   end

endmodule

// File: tb/tb_lz77_frame_ctrl.sv
// Self-checking bench for lz77_frame_ctrl: the bench plays the encoder core, emitting tokens
// from a greedy LZ77 model of the bytes the core received, and tracks the FIFO as a queue.
module tb_lz77_frame_ctrl;
   localparam int N = 2049;
   localparam int DEPTH = 4;

   logic        clk, reset, in_valid, in_ready, core_rst, core_valid, core_finish;
   logic        tok_valid, tok_ready, busy, frame_done;
   logic [7:0]  in_data, core_char, core_nxt;
   logic [3:0]  core_offset;
   logic [2:0]  core_len, err;
   logic [14:0] tok_data;

   lz77_frame_ctrl #(.FRAME_LEN(N), .TOK_DEPTH(DEPTH), .TERM(8'h24)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .core_rst(core_rst), .core_char(core_char), .core_valid(core_valid),
      .core_offset(core_offset), .core_len(core_len), .core_nxt(core_nxt),
      .core_finish(core_finish), .tok_valid(tok_valid), .tok_ready(tok_ready),
      .tok_data(tok_data), .busy(busy), .frame_done(frame_done), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_mis = 0;
   logic [7:0]  fbytes [N];
   logic [7:0]  seen   [N];
   logic [14:0] toks[$];
   logic [14:0] model_q[$];
   logic [2:0]  exp_err;

   typedef struct {
      logic       rst_n;
      logic       vld;
      logic [7:0] dat;
      logic [15:0] exp;  // {in_ready, core_rst, busy, tok_valid, frame_done, err, core_char}
   } vec_t;
   vec_t vecs [4];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Greedy LZ77: window of 15, match up to 7, each token covers len+1 chars ending in nxt.
   function automatic void lz_model();
      int pos = 0;
      toks.delete();
      while (pos < N) begin
         int bl = 0;
         int bo = 0;
         for (int off = 1; off <= 15; off++) begin
            if (off <= pos) begin
               int l = 0;
               while (l < 7 && pos + l < N - 1 && seen[pos + l - off] == seen[pos + l]) l++;
               if (l > bl) begin bl = l; bo = off; end
            end
         end
         toks.push_back({4'(bo), 3'(bl), seen[pos + bl]});
         pos += bl + 1;
      end
   endfunction

   function automatic bit ready_of(input int mode, input int c);
      case (mode)
         0:       return 1'b1;
         1:       return 1'($urandom_range(0, 1));
         2:       return (c >= 8);
         default: return (c >= 4);
      endcase
   endfunction

   task automatic model_step(input bit ready, input bit emit, input logic [14:0] t, inout int bad);
      bit pop, was_full;
      if (tok_valid !== (model_q.size() != 0)) bad++;
      else if (tok_valid && tok_data !== model_q[0]) bad++;
      pop = (model_q.size() != 0) && ready;
      was_full = (model_q.size() == DEPTH);
      if (pop) void'(model_q.pop_front());
      if (emit) begin
         if (was_full && !pop) exp_err[1] = 1'b1;
         else model_q.push_back(t);
      end
   endtask

   // rmode: tok_ready policy; emode 0 = token every cycle, 1 = random gaps;
   // tmode 1 = omit first token (short coverage), 2 = last nxt replaced by 8'h41.
   task automatic run_frame(input bit skip_start, input int drop_at, input int abort_at,
                            input int rmode, input int emode, input int tmode, input string tag);
      int bad = 0, rdy = 0, c = 0, c2 = 0, idx = 0, cov = 0;
      bit fin = 0, done_next = 0, got_done = 0, emit, ready;
      logic [7:0]  last_nxt = 8'h00;
      logic [14:0] t;
      for (int i = 0; i < N; i++) seen[i] = (i == drop_at) ? 8'h00 : fbytes[i];
      lz_model();
      if (tmode == 1) void'(toks.pop_front());
      if (tmode == 2) begin t = toks.pop_back(); t[7:0] = 8'h41; toks.push_back(t); end
      model_q.delete();
      core_valid = 0; core_finish = 0; tok_ready = 1;
      if (!skip_start) begin
         step(); in_valid = 1; in_data = fbytes[0]; #1;
         check($sformatf("%s/idle", tag), {core_rst, busy, in_ready, frame_done}, 4'b1000);
         step(); #1;
         check($sformatf("%s/crst", tag), {core_rst, busy, in_ready, frame_done}, 4'b1100);
      end
      for (int i = 0; i < N; i++) begin
         step();
         if (i == abort_at) begin
            in_valid = 1; reset = 0; #1;
            check($sformatf("%s/abort_out", tag), {in_ready, core_rst, busy, tok_valid, frame_done}, 5'b01000);
            check($sformatf("%s/abort_err", tag), err, 3'b000);
            exp_err = 3'b000;
            for (int k = 0; k < 3; k++) begin
               step(); #1;
               if (frame_done !== 0 || busy !== 0) bad++;
            end
            step(); reset = 1; in_valid = 0;
            check($sformatf("%s/abort_hold", tag), bad, 0);
            return;
         end
         in_valid = (i != drop_at);
         in_data = (i == drop_at) ? 8'($urandom) : fbytes[i];
         core_valid = 1'($urandom); core_finish = 1'($urandom); tok_ready = 1'($urandom);
         #1;
         if (in_ready === 1'b1) rdy++;
         if (core_char !== seen[i] || core_rst !== 0 || busy !== 1 || frame_done !== 0 || tok_valid !== 0) bad++;
      end
      if (drop_at >= 0) exp_err[0] = 1'b1;
      check($sformatf("%s/load_bad", tag), bad, 0);
      check($sformatf("%s/load_cycles", tag), rdy, N);
      while (!fin && c < 4 * N + 64) begin
         step();
         emit = (idx < toks.size()) && (emode == 0 || $urandom_range(0, 2) != 0);
         t = emit ? toks[idx] : 15'($urandom);
         if (emit) idx++;
         fin = (idx == toks.size()) && (emode == 0 || $urandom_range(0, 1) == 1);
         ready = ready_of(rmode, c);
         in_valid = 1; in_data = 8'($urandom);
         core_valid = emit; {core_offset, core_len, core_nxt} = t; core_finish = fin; tok_ready = ready;
         #1;
         if (c == 0) check($sformatf("%s/enc_in_ready", tag), in_ready, 1'b0);
         if (in_ready !== 0 || frame_done !== 0 || busy !== 1) bad++;
         model_step(ready, emit, t, bad);
         if (emit) begin cov += int'(t[10:8]) + 1; last_nxt = t[7:0]; end
         c++;
      end
      check($sformatf("%s/enc_finished", tag), fin, 1'b1);
      while (!got_done && c2 < 300) begin
         step();
         ready = ready_of(rmode, c);
         in_valid = 1'($urandom); core_valid = 1'($urandom); core_finish = 1'($urandom);
         {core_offset, core_len, core_nxt} = 15'($urandom); tok_ready = ready;
         #1;
         if (done_next) begin
            if (cov != N || last_nxt != 8'h24) exp_err[2] = 1'b1;
            check($sformatf("%s/done_out", tag), {frame_done, busy, tok_valid, in_ready}, 4'b1100);
            check($sformatf("%s/done_err", tag), err, exp_err);
            got_done = 1;
         end else begin
            if (frame_done !== 0 || in_ready !== 0) bad++;
            done_next = (model_q.size() == 0);
            model_step(ready, 1'b0, t, bad);
         end
         c++; c2++;
      end
      check($sformatf("%s/drain_done", tag), got_done, 1'b1);
      check($sformatf("%s/frame_bad", tag), bad, 0);
   endtask

   initial begin
      reset = 1; in_valid = 0; in_data = 0; core_valid = 0; core_offset = 0; core_len = 0;
      core_nxt = 0; core_finish = 0; tok_ready = 0; exp_err = 3'b000;
      #2 reset = 0;
      for (int i = 0; i < N - 1; i++) fbytes[i] = 8'(8'h61 + i % 26);
      fbytes[N - 1] = 8'h24;

      vecs[0] = '{1'b0, 1'b1, 8'h61, {5'b01000, 3'b000, 8'h00}};
      vecs[1] = '{1'b1, 1'b0, 8'h61, {5'b01000, 3'b000, 8'h00}};
      vecs[2] = '{1'b1, 1'b1, 8'h61, {5'b01000, 3'b000, 8'h00}};
      vecs[3] = '{1'b1, 1'b1, 8'h61, {5'b01100, 3'b000, 8'h00}};
      for (int v = 0; v < 4; v++) begin
         step();
         reset = vecs[v].rst_n; in_valid = vecs[v].vld; in_data = vecs[v].dat;
         #1;
         check($sformatf("vec%0d", v), {in_ready, core_rst, busy, tok_valid, frame_done, err, core_char},
               vecs[v].exp);
      end

      run_frame(1, -1, -1, 0, 0, 0, "nominal");
      run_frame(0, -1, -1, 3, 0, 0, "full_pushpop");
      for (int i = 0; i < N - 1; i++) fbytes[i] = 8'(8'h61 + $urandom_range(0, 2));
      run_frame(0, -1, -1, 1, 1, 0, "random");
      for (int i = 0; i < N - 1; i++) fbytes[i] = 8'(8'h61 + i % 26);
      run_frame(0, 100, -1, 0, 0, 0, "underrun");
      run_frame(0, -1, -1, 2, 0, 0, "backpressure");
      run_frame(0, -1, -1, 0, 0, 1, "cov_short");
      step(); in_valid = 0; reset = 0; #1;
      check("reset_clears_err", err, 3'b000);
      exp_err = 3'b000;
      step(); reset = 1;
      run_frame(0, -1, -1, 0, 0, 2, "bad_term");
      run_frame(0, -1, 500, 1, 1, 0, "abort");
      run_frame(0, -1, -1, 0, 0, 0, "fresh");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end
endmodule

// File: doc/lz77_frame_ctrl.md
Name: lz77_frame_ctrl

Overview:
- Sequences one LZ77 encoder core (8-bit char in; 4-bit offset, 3-bit match_len and 8-bit next-char token out) over consecutive frames.
- Resets the core per frame, streams exactly FRAME_LEN bytes into it, then collects the emitted tokens into a small FIFO with a valid/ready output.
- Checks token coverage against the frame length and raises sticky error flags.
- Sits between the byte source and the token packer.

Parameters:
- FRAME_LEN, 2049, bytes per frame including terminator; the core's fixed load count.
- TOK_DEPTH, 4, token FIFO depth (power of 2, >=2).
- TERM, 8'h24, terminator char expected as char_nxt of the last token.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous active-low reset
- in_valid  in  1  upstream byte valid
- in_data  in  8  upstream byte
- in_ready  out  1  upstream byte accepted when in_valid&in_ready
- core_rst  out  1  active-high synchronous reset to the core
- core_char  out  8  chardata to the core
- core_valid  in  1  core token valid (1-cycle pulse)
- core_offset  in  4  token offset
- core_len  in  3  token match length
- core_nxt  in  8  token next char
- core_finish  in  1  core done (level)
- tok_valid  out  1  FIFO head valid
- tok_ready  in  1  downstream accept
- tok_data  out  15  {offset[14:11], len[10:8], char[7:0]}
- busy  out  1  high in any state except IDLE
- frame_done  out  1  1-cycle pulse at end of frame
- err  out  3  sticky {coverage, overflow, underrun}; cleared only by reset

Behaviour:
- Async reset (reset=0): state=IDLE, all counters and FIFO pointers 0, core_rst=1, in_ready=0, core_char=0, tok_valid=0, frame_done=0, err=0, busy=0.
- States: IDLE, CRST, LOAD, ENC, DRAIN, DONE.
- IDLE: core_rst=1. When in_valid=1, go to CRST. No byte is consumed.
- CRST: core_rst=1 for exactly one cycle, then go to LOAD with byte_cnt=0.
- LOAD: core_rst=0, in_ready=1. core_char is combinationally driven by in_data. Every LOAD cycle counts as one byte delivered to the core, so byte_cnt increments every cycle regardless of in_valid.
  - A LOAD cycle with in_valid=0 sets err[0] (underrun) and drives core_char=8'h00.
  - When byte_cnt==FRAME_LEN-1, that cycle is the last byte; go to ENC. Exactly FRAME_LEN bytes are accepted per frame.
- ENC: in_ready=0, core_rst=0.
  - Each core_valid pushes {offset,len,nxt} into the FIFO and adds len+1 to cov_cnt (12-bit, saturating at 4095).
  - The most recent nxt is kept in last_char.
  - When core_finish=1, go to DRAIN. A core_valid in the same cycle is still captured.
- DRAIN: wait for the FIFO to be empty, then go to DONE.
- DONE: frame_done=1 for one cycle.
  - Set err[2] if cov_cnt!=FRAME_LEN or last_char!=TERM.
  - Then go to IDLE: core_rst=1, cov_cnt cleared.
- Token FIFO:
  - Registered output; tok_valid=~empty; tok_data=head entry.
  - Pop when tok_valid&tok_ready.
  - A push while full drops the token and sets err[1]. A pop and push in the same cycle while full is legal and is not an overflow.
  - Push into an empty FIFO gives tok_valid=1 on the next cycle (1-cycle latency). Pointers wrap modulo TOK_DEPTH.
- core_valid outside ENC is ignored. core_finish outside ENC is ignored.
- Reset asserted mid-frame aborts immediately to the reset values. A partial frame is discarded with no frame_done.
- Back-to-back frames: IDLE→CRST is taken on the cycle after DONE if in_valid=1.

Test Plan:
- Nominal frame: 2048 bytes "a".."z" repeating plus 8'h24, in_valid held high, tok_ready=1. Required: 2049 in_ready cycles; tokens match the golden model; cov_cnt=2049; one frame_done pulse; err=3'b000.
- Underrun: drop in_valid for 1 cycle at byte 100. Required: byte_cnt still reaches 2049 in 2049 cycles; core sees 8'h00 at index 100; err[0]=1 and stays set through the next frame.
- Backpressure: tok_ready=0 while 5 tokens arrive (TOK_DEPTH=4). Required: 4 tokens held with tok_valid=1; 5th dropped; err[1]=1; DRAIN waits until tok_ready releases the 4.
- Full FIFO with simultaneous push/pop: FIFO full, tok_ready=1 and core_valid=1 in the same cycle. Required: no overflow; count stays 4; order preserved.
- Coverage error: stub core emits tokens totalling 2048 chars, then core_finish. Required: frame_done pulse with err[2]=1. A second stub whose last nxt=8'h41 also sets err[2].
- Mid-frame reset: reset=0 at LOAD byte 500. Required: immediate in_ready=0, core_rst=1, busy=0, tok_valid=0, no frame_done. After release, a fresh frame completes normally.
